// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge port of the fetch stage.
// The fetch stage is master: it holds req/addr until ack, and the memory returns rdata with ack.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register of the 5-stage MIPS pipeline, with a variable-latency imem port.
// Build option FETCH_DELAY_SLOT_EN keeps the word fetched after a taken branch/jump (delay slot).
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          PCSrcD,
  input  logic          Jump,
  input  logic [31:0]   PCBranchD,
  input  logic [31:0]   JA,
  fetch_stage_if.master imem,
  output logic [31:0]   InstrD,
  output logic [31:0]   PCPlus4D,
  output logic          fetch_busy
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] tgt_q, tgt_d;
  logic        pend_q, pend_d;

  logic [31:0] pcf_plus4;
  logic [31:0] target;
  logic        redir;
  logic        unused_ja;

  assign pcf_plus4 = pcf_q + 32'd4;
  assign target    = Jump ? {pcp4_q[31:28], JA[27:0]} : PCBranchD;
  assign redir     = PCSrcD & ~stall;
  assign unused_ja = ^JA[31:28];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcf_q   <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcp4_q  <= 32'd0;
      buf_q   <= 32'd0;
      tgt_q   <= 32'd0;
      pend_q  <= 1'b0;
    end else begin
      pcf_q   <= pcf_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      buf_q   <= buf_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
    end
  end

  // NOTE: every output of this block gets a hold-value default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    pcf_d   = pcf_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    buf_d   = buf_q;
    tgt_d   = tgt_q;
    pend_d  = pend_q;
    unique case (state_q)
      FETCH: begin
        if (imem.imem_ack) begin
          if (stall) begin
            buf_d   = imem.imem_rdata;
            state_d = HOLD;
          end else if (PCSrcD) begin
`ifdef FETCH_DELAY_SLOT_EN
            instr_d = imem.imem_rdata;
            pcp4_d  = pcf_plus4;
`else
            instr_d = NOP_INSTR;
`endif
            pcf_d   = target;
          end else begin
            instr_d = imem.imem_rdata;
            pcp4_d  = pcf_plus4;
            pcf_d   = pcf_plus4;
          end
        end else if (!stall) begin
          instr_d = NOP_INSTR;
          if (PCSrcD) begin
            tgt_d   = target;
            state_d = DROP;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          state_d = FETCH;
          pend_d  = 1'b0;
          // A redirect seen now overrides one left pending from DROP.
          if (pend_q || PCSrcD) begin
            pcf_d = PCSrcD ? target : tgt_q;
`ifdef FETCH_DELAY_SLOT_EN
            instr_d = buf_q;
            pcp4_d  = pcf_plus4;
`else
            instr_d = NOP_INSTR;
`endif
          end else begin
            instr_d = buf_q;
            pcp4_d  = pcf_plus4;
            pcf_d   = pcf_plus4;
          end
        end
      end
      DROP: begin
        if (redir) tgt_d = target;
        if (imem.imem_ack) begin
          if (stall) begin
            // PCF may not move under stall: park the word and finish the redirect from HOLD.
            buf_d   = imem.imem_rdata;
            pend_d  = 1'b1;
            state_d = HOLD;
          end else begin
            pcf_d   = redir ? target : tgt_q;
            state_d = FETCH;
`ifdef FETCH_DELAY_SLOT_EN
            instr_d = imem.imem_rdata;
            pcp4_d  = pcf_plus4;
`else
            instr_d = NOP_INSTR;
`endif
          end
        end else if (!stall) begin
          instr_d = NOP_INSTR;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem.imem_req  = rst && (state_q != HOLD);
    imem.imem_addr = pcf_q;
    fetch_busy     = ((state_q == FETCH) && !imem.imem_ack) || (state_q == DROP);
    InstrD         = instr_q;
    PCPlus4D       = pcp4_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: variable-latency memory model, scoreboard of IF/ID deliveries,
// and immediate-assertion checks of addresses, handshake and reset behaviour.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, PCSrcD, Jump;
  logic [31:0] PCBranchD, JA;
  logic [31:0] InstrD, PCPlus4D;
  logic        fetch_busy;

  int   checks = 0;
  int   errors = 0;
  int   lat    = 0;
  int   wait_cnt;
  exp_t exp_q[$];

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .PCSrcD     (PCSrcD),
    .Jump       (Jump),
    .PCBranchD  (PCBranchD),
    .JA         (JA),
    .imem       (bus),
    .InstrD     (InstrD),
    .PCPlus4D   (PCPlus4D),
    .fetch_busy (fetch_busy)
  );

  always #5 clk = ~clk;

  // Memory: ack in the (lat+1)-th cycle of a request; each word is the inverted address.
  assign bus.imem_ack   = bus.imem_req && (wait_cnt >= lat);
  assign bus.imem_rdata = ~bus.imem_addr;

  always @(posedge clk or negedge rst) begin
    if (!rst)             wait_cnt <= 0;
    else if (bus.imem_ack) wait_cnt <= 0;
    else if (bus.imem_req) wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] addr);
    exp_q.push_back('{instr: ~addr, pc4: addr + 32'd4});
  endtask

  // Scoreboard: each new non-bubble IF/ID content must match the oldest expected delivery.
  initial begin : monitor
    logic [63:0] prev, cur;
    exp_t        e;
    prev = '0;
    forever begin
      @(posedge clk);
      #1;
      cur = {InstrD, PCPlus4D};
      if (rst && InstrD !== NOP && cur !== prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_delivery", InstrD, NOP);
        end else begin
          e = exp_q.pop_front();
          check("sb_instr", InstrD, e.instr);
          check("sb_pcplus4", PCPlus4D, e.pc4);
        end
      end
      prev = cur;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; PCSrcD = 1'b0; Jump = 1'b0;
    PCBranchD = '0; JA = '0; lat = 0;
    repeat (2) @(negedge clk);
    check("rst_instr", InstrD, NOP);
    check("rst_pcplus4", PCPlus4D, 32'd0);
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);

    // Zero-wait memory, sequential fetch.
    rst = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("zw_addr", bus.imem_addr, 32'(4 * i));
      check("zw_busy", {31'd0, fetch_busy}, 32'd0);
      check("zw_req", {31'd0, bus.imem_req}, 32'd1);
      push(32'(4 * i));
    end

    // Three-cycle latency.
    @(negedge clk);
    lat = 2;
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) begin
        if (!(k == 0 && j == 0)) @(negedge clk);
        check("lat_addr", bus.imem_addr, 32'(20 + 4 * k));
        check("lat_busy", {31'd0, fetch_busy}, (j < 2) ? 32'd1 : 32'd0);
        if (j > 0) check("lat_bubble", InstrD, NOP);
        if (j == 0) push(32'(20 + 4 * k));
      end
    end

    // Stall for four cycles with the ack arriving in the second.
    @(negedge clk);
    stall = 1'b1; lat = 1;
    push(32'd28);
    #1;
    check("stall_req0", {31'd0, bus.imem_req}, 32'd1);
    for (int s = 1; s < 4; s++) begin
      @(negedge clk);
      check("stall_instr", InstrD, ~32'd24);
      check("stall_pcplus4", PCPlus4D, 32'd28);
      check("stall_addr", bus.imem_addr, 32'd28);
      check("stall_req", {31'd0, bus.imem_req}, (s == 1) ? 32'd1 : 32'd0);
      if (s > 1) check("stall_busy", {31'd0, fetch_busy}, 32'd0);
    end
    @(negedge clk);
    check("stall_hold_instr", InstrD, ~32'd24);
    stall = 1'b0;
    @(negedge clk);
    check("no_refetch_addr", bus.imem_addr, 32'd32);
    check("no_refetch_busy", {31'd0, fetch_busy}, 32'd1);

    // Branch while the request is outstanding.
    PCSrcD = 1'b1; Jump = 1'b0; PCBranchD = 32'h40;
`ifdef FETCH_DELAY_SLOT_EN
    push(32'd32);
`endif
    @(negedge clk);
    PCSrcD = 1'b0;
    #1;
    check("drop_addr", bus.imem_addr, 32'd32);
    check("drop_busy", {31'd0, fetch_busy}, 32'd1);
    check("drop_req", {31'd0, bus.imem_req}, 32'd1);
    check("drop_bubble", InstrD, NOP);
    @(negedge clk);
    check("branch_addr", bus.imem_addr, 32'h40);
`ifndef FETCH_DELAY_SLOT_EN
    check("branch_squash", InstrD, NOP);
`endif
    push(32'h40);
    repeat (2) @(negedge clk);
    check("after_branch_addr", bus.imem_addr, 32'h44);

    // Branch with the ack in the same cycle, then a jump using PCPlus4D[31:28].
    lat = 0;
    PCSrcD = 1'b1; PCBranchD = 32'h1000_000C;
`ifdef FETCH_DELAY_SLOT_EN
    push(32'h44);
`endif
    @(negedge clk);
    PCSrcD = 1'b0;
    check("ack_branch_addr", bus.imem_addr, 32'h1000_000C);
`ifndef FETCH_DELAY_SLOT_EN
    check("ack_branch_squash", InstrD, NOP);
`endif
    push(32'h1000_000C);
    @(negedge clk);
    check("jump_pcplus4", PCPlus4D, 32'h1000_0010);
    PCSrcD = 1'b1; Jump = 1'b1; JA = 32'h0000_0100;
`ifdef FETCH_DELAY_SLOT_EN
    push(32'h1000_0010);
`endif
    @(negedge clk);
    PCSrcD = 1'b0; Jump = 1'b0;
    check("jump_addr", bus.imem_addr, 32'h1000_0100);
    push(32'h1000_0100);

    // Reset in the middle of DROP, then the PC wrap.
    @(negedge clk);
    lat = 1;
    PCSrcD = 1'b1; PCBranchD = 32'h80;
    @(negedge clk);
    PCSrcD = 1'b0;
    #1;
    check("mid_drop_busy", {31'd0, fetch_busy}, 32'd1);
    check("mid_drop_addr", bus.imem_addr, 32'h1000_0104);
    rst = 1'b0;
    #1;
    check("async_rst_instr", InstrD, NOP);
    check("async_rst_pcplus4", PCPlus4D, 32'd0);
    check("async_rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("async_rst_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1; lat = 0;
    #1;
    check("rerelease_addr", bus.imem_addr, 32'h0);
    check("rerelease_req", {31'd0, bus.imem_req}, 32'd1);
    PCSrcD = 1'b1; PCBranchD = 32'hFFFF_FFFC;
`ifdef FETCH_DELAY_SLOT_EN
    push(32'h0);
`endif
    @(negedge clk);
    PCSrcD = 1'b0;
    check("wrap_fetch_addr", bus.imem_addr, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_pcplus4", PCPlus4D, 32'h0);
    check("wrap_instr", InstrD, 32'h0000_0003);
    check("wrap_addr", bus.imem_addr, 32'h0);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
